// File: rtl/lease_cache_mem_arbiter.sv
// Purpose: round-robin share of one memory-controller request/buffer port between icache (port 0) and dcache (port 1).
// Latency: a request pulse reaches mem_req_o one cycle later at the earliest; beats pass combinationally while in XFER.
// Backpressure: ready_req is withheld while busy or pending, ISSUE waits on mem_ready_req_i, beats follow the buffer readies.
// Optional build macro LEASE_ARB_PERF_COUNTERS_EN adds grant/collision/stall counters on perf_sel_i/perf_data_o.
module lease_cache_mem_arbiter #(
  parameter int BW_ADDR     = 24,
  parameter int BLOCK_WORDS = 16
) (
  input  logic               clock_i,
  input  logic               resetn_i,
  input  logic               r0_req_i,
  input  logic               r1_req_i,
  input  logic               r0_req_block_i,
  input  logic               r1_req_block_i,
  input  logic               r0_rw_i,
  input  logic               r1_rw_i,
  input  logic [BW_ADDR-1:0] r0_add_i,
  input  logic [BW_ADDR-1:0] r1_add_i,
  input  logic               r0_write_i,
  input  logic               r1_write_i,
  input  logic               r0_read_i,
  input  logic               r1_read_i,
  input  logic [31:0]        r0_data_i,
  input  logic [31:0]        r1_data_i,
  output logic               r0_ready_req_o,
  output logic               r1_ready_req_o,
  output logic               r0_ready_write_o,
  output logic               r1_ready_write_o,
  output logic               r0_ready_read_o,
  output logic               r1_ready_read_o,
  output logic [31:0]        rd_data_o,
  input  logic               mem_ready_req_i,
  input  logic               mem_ready_write_i,
  input  logic               mem_ready_read_i,
  input  logic [31:0]        mem_data_i,
  output logic               mem_req_o,
  output logic               mem_req_block_o,
  output logic               mem_rw_o,
  output logic [BW_ADDR-1:0] mem_add_o,
  output logic               mem_write_o,
  output logic               mem_read_o,
  output logic [31:0]        mem_data_o,
  output logic [1:0]         grant_o,
  output logic               busy_o,
  input  logic [1:0]         perf_sel_i,
  output logic [31:0]        perf_data_o
);

  localparam int CW = $clog2(BLOCK_WORDS) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;

  typedef struct packed {
    logic               block;
    logic               rw;
    logic [BW_ADDR-1:0] add;
    logic               owner;
  } req_t;

  state_t        state_q, state_d;
  req_t          act_q, act_d;
  req_t          pend_q, pend_d;
  req_t          req0, req1;
  logic          pend_vld_q, pend_vld_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last_beat;
  logic          load_act;
  logic          beat;
  logic          own_write, own_read;
  logic [31:0]   own_data;
  logic [1:0]    owner_oh;

  assign req0 = '{block: r0_req_block_i, rw: r0_rw_i, add: r0_add_i, owner: 1'b0};
  assign req1 = '{block: r1_req_block_i, rw: r1_rw_i, add: r1_add_i, owner: 1'b1};

  // Only the owning requester's strobes and data are ever looked at.
  assign own_write = act_q.owner ? r1_write_i : r0_write_i;
  assign own_read  = act_q.owner ? r1_read_i  : r0_read_i;
  assign own_data  = act_q.owner ? r1_data_i  : r0_data_i;
  assign owner_oh  = act_q.owner ? 2'b10 : 2'b01;

  // Index of the final beat: a block ends on BLOCK_WORDS-1, a single word on 0.
  assign last_beat = act_q.block ? CW'(BLOCK_WORDS - 1) : '0;

  // Read data is broadcast; only the owner is told it is valid.
  assign rd_data_o = mem_data_i;

  // FSM state register
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state, request capture/arbitration and all handshake outputs
  always_comb begin
    state_d          = state_q;
    act_d            = act_q;
    pend_d           = pend_q;
    pend_vld_d       = pend_vld_q;
    ptr_d            = ptr_q;
    cnt_d            = cnt_q;
    load_act         = 1'b0;
    beat             = 1'b0;
    r0_ready_req_o   = 1'b0;
    r1_ready_req_o   = 1'b0;
    r0_ready_write_o = 1'b0;
    r1_ready_write_o = 1'b0;
    r0_ready_read_o  = 1'b0;
    r1_ready_read_o  = 1'b0;
    mem_req_o        = 1'b0;
    mem_req_block_o  = 1'b0;
    mem_rw_o         = 1'b0;
    mem_add_o        = '0;
    mem_write_o      = 1'b0;
    mem_read_o       = 1'b0;
    mem_data_o       = '0;
    grant_o          = 2'b00;
    busy_o           = 1'b0;

    case (state_q)
      IDLE: begin
        // resetn_i gating keeps every output low while reset is held.
        r0_ready_req_o = mem_ready_req_i & ~pend_vld_q & resetn_i;
        r1_ready_req_o = mem_ready_req_i & ~pend_vld_q & resetn_i;
        if (pend_vld_q) begin
          // The collision loser goes next, ahead of any fresh request.
          act_d      = pend_q;
          pend_vld_d = 1'b0;
          load_act   = 1'b1;
        end else if (r0_req_i && r1_req_i) begin
          act_d      = ptr_q ? req1 : req0;
          pend_d     = ptr_q ? req0 : req1;
          pend_vld_d = 1'b1;
          load_act   = 1'b1;
        end else if (r0_req_i) begin
          act_d    = req0;
          load_act = 1'b1;
        end else if (r1_req_i) begin
          act_d    = req1;
          load_act = 1'b1;
        end
        if (load_act) state_d = ISSUE;
      end

      ISSUE: begin
        busy_o  = 1'b1;
        grant_o = owner_oh;
        if (mem_ready_req_i) begin
          mem_req_o       = 1'b1;
          mem_req_block_o = act_q.block;
          mem_rw_o        = act_q.rw;
          mem_add_o       = act_q.add;
          cnt_d           = '0;
          state_d         = XFER;
        end
      end

      XFER: begin
        busy_o     = 1'b1;
        grant_o    = owner_oh;
        mem_data_o = own_data;
        if (act_q.rw) begin
          r0_ready_write_o = mem_ready_write_i & ~act_q.owner;
          r1_ready_write_o = mem_ready_write_i &  act_q.owner;
          mem_write_o      = own_write & mem_ready_write_i;
        end else begin
          r0_ready_read_o  = mem_ready_read_i & ~act_q.owner;
          r1_ready_read_o  = mem_ready_read_i &  act_q.owner;
          mem_read_o       = own_read & mem_ready_read_i;
        end
        beat = mem_write_o | mem_read_o;
        if (beat) begin
          // Counter stops at BLOCK_WORDS at most and is cleared in ISSUE, so it cannot wrap.
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == last_beat) begin
            state_d = IDLE;
            ptr_d   = ~act_q.owner;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Active and pending request registers, round-robin pointer and beat counter
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ptr_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef LEASE_ARB_PERF_COUNTERS_EN
  // Selector map: 0 port0 grants, 1 port1 grants, 2 collision cycles, 3 ISSUE stall cycles.
  logic [31:0] perf_q [4];
  logic [3:0]  perf_inc;

  assign perf_inc[0] = load_act & ~act_d.owner;
  assign perf_inc[1] = load_act &  act_d.owner;
  assign perf_inc[2] = r0_req_i & r1_req_i;
  assign perf_inc[3] = (state_q == ISSUE) & ~mem_ready_req_i;

  // Saturating event counters
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < 4; i++) perf_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (perf_inc[i] && (perf_q[i] != 32'hFFFF_FFFF)) perf_q[i] <= perf_q[i] + 32'd1;
      end
    end
  end

  assign perf_data_o = perf_q[perf_sel_i];
`else
  logic unused_perf_sel;
  assign unused_perf_sel = ^perf_sel_i;
  assign perf_data_o     = '0;
`endif

endmodule

// File: tb/tb_lease_cache_mem_arbiter.sv
// Purpose: self-checking bench for lease_cache_mem_arbiter; directed scenarios then randomized traffic.
// Latency: inputs change on the falling edge, outputs are sampled 2 time units later.
// Backpressure: requesters only pulse when the transaction-level model says the arbiter is idle and ready.
module tb_lease_cache_mem_arbiter;

  localparam int AW = 24;
  localparam int BW = 16;

  logic          clock_i = 1'b0;
  logic          resetn_i = 1'b1;
  logic          r0_req_i = 1'b0, r1_req_i = 1'b0;
  logic          r0_req_block_i = 1'b0, r1_req_block_i = 1'b0;
  logic          r0_rw_i = 1'b0, r1_rw_i = 1'b0;
  logic [AW-1:0] r0_add_i = '0, r1_add_i = '0;
  logic          r0_write_i = 1'b0, r1_write_i = 1'b0;
  logic          r0_read_i = 1'b0, r1_read_i = 1'b0;
  logic [31:0]   r0_data_i = '0, r1_data_i = '0;
  logic          r0_ready_req_o, r1_ready_req_o;
  logic          r0_ready_write_o, r1_ready_write_o;
  logic          r0_ready_read_o, r1_ready_read_o;
  logic [31:0]   rd_data_o;
  logic          mem_ready_req_i = 1'b1, mem_ready_write_i = 1'b1, mem_ready_read_i = 1'b1;
  logic [31:0]   mem_data_i = 32'h0;
  logic          mem_req_o, mem_req_block_o, mem_rw_o;
  logic [AW-1:0] mem_add_o;
  logic          mem_write_o, mem_read_o;
  logic [31:0]   mem_data_o;
  logic [1:0]    grant_o;
  logic          busy_o;
  logic [1:0]    perf_sel_i = 2'b00;
  logic [31:0]   perf_data_o;

  lease_cache_mem_arbiter #(.BW_ADDR(AW), .BLOCK_WORDS(BW)) dut (
    .clock_i(clock_i), .resetn_i(resetn_i),
    .r0_req_i(r0_req_i), .r1_req_i(r1_req_i),
    .r0_req_block_i(r0_req_block_i), .r1_req_block_i(r1_req_block_i),
    .r0_rw_i(r0_rw_i), .r1_rw_i(r1_rw_i),
    .r0_add_i(r0_add_i), .r1_add_i(r1_add_i),
    .r0_write_i(r0_write_i), .r1_write_i(r1_write_i),
    .r0_read_i(r0_read_i), .r1_read_i(r1_read_i),
    .r0_data_i(r0_data_i), .r1_data_i(r1_data_i),
    .r0_ready_req_o(r0_ready_req_o), .r1_ready_req_o(r1_ready_req_o),
    .r0_ready_write_o(r0_ready_write_o), .r1_ready_write_o(r1_ready_write_o),
    .r0_ready_read_o(r0_ready_read_o), .r1_ready_read_o(r1_ready_read_o),
    .rd_data_o(rd_data_o),
    .mem_ready_req_i(mem_ready_req_i), .mem_ready_write_i(mem_ready_write_i),
    .mem_ready_read_i(mem_ready_read_i), .mem_data_i(mem_data_i),
    .mem_req_o(mem_req_o), .mem_req_block_o(mem_req_block_o), .mem_rw_o(mem_rw_o),
    .mem_add_o(mem_add_o), .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
    .mem_data_o(mem_data_o), .grant_o(grant_o), .busy_o(busy_o),
    .perf_sel_i(perf_sel_i), .perf_data_o(perf_data_o)
  );

  always #5 clock_i = ~clock_i;

  int total = 0;
  int bad   = 0;

  // Transaction-level reference: a transaction is waiting for its command (phase 1)
  // or moving its remaining beats (phase 2); phase 0 means nothing is owned.
  typedef struct packed {
    bit          blk;
    bit          rw;
    bit [AW-1:0] add;
    bit          own;
  } txn_t;

  txn_t cur;
  txn_t pend[$];
  int   phase = 0;
  int   remaining = 0;
  bit   ptr = 1'b0;
  int   cyc = 0;

  // Observations of the DUT, accumulated per scenario.
  int          n_cmd, n_beat, n_rr, n_r1rdy, n_busy;
  logic [1:0]  glog[$];
  logic [AW-1:0] last_add;
  logic        last_blk, last_rw, last_busy;
  logic [31:0] last_data;
  logic [31:0] perf_exp [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_cmd = 0; n_beat = 0; n_rr = 0; n_r1rdy = 0; n_busy = 0;
    glog.delete();
  endtask

  function automatic logic [31:0] glog_at(input int i);
    return (glog.size() > i) ? 32'(glog[i]) : 32'hFFFF;
  endfunction

  function automatic txn_t mk(input bit p);
    txn_t t;
    if (p) t = '{blk: r1_req_block_i, rw: r1_rw_i, add: r1_add_i, own: 1'b1};
    else   t = '{blk: r0_req_block_i, rw: r0_rw_i, add: r0_add_i, own: 1'b0};
    return t;
  endfunction

  // One clock: compare every output against the model, record observations, advance the model.
  task automatic step();
    logic [101:0] obs, exp, msk;
    bit           xfer, e_req, e_rr, ow, orr, e_wr, e_rd, fired;
    logic [31:0]  od;
    txn_t         t0, t1;
    #2;
    obs = {busy_o, grant_o, r0_ready_req_o, r1_ready_req_o, r0_ready_write_o, r1_ready_write_o,
           r0_ready_read_o, r1_ready_read_o, mem_req_o, mem_req_block_o, mem_rw_o, mem_add_o,
           mem_write_o, mem_read_o, mem_data_o, rd_data_o};
    xfer  = (phase == 2);
    e_req = (phase == 1) && mem_ready_req_i;
    e_rr  = (phase == 0) && (pend.size() == 0) && mem_ready_req_i;
    ow    = cur.own ? r1_write_i : r0_write_i;
    orr   = cur.own ? r1_read_i  : r0_read_i;
    od    = cur.own ? r1_data_i  : r0_data_i;
    e_wr  = xfer && cur.rw && mem_ready_write_i;
    e_rd  = xfer && !cur.rw && mem_ready_read_i;
    fired = (e_wr && ow) || (e_rd && orr);
    if (!resetn_i) begin
      exp = {70'd0, mem_data_i};
      msk = '1;
    end else begin
      exp = {phase != 0, (phase == 0) ? 2'b00 : (cur.own ? 2'b10 : 2'b01), e_rr, e_rr,
             e_wr && !cur.own, e_wr && cur.own, e_rd && !cur.own, e_rd && cur.own,
             e_req, cur.blk, cur.rw, cur.add, e_wr && ow, e_rd && orr, od, mem_data_i};
      msk = {9'h1ff, 1'b1, {26{e_req}}, 2'b11, {32{xfer}}, 32'hFFFF_FFFF};
    end
    total++;
    assert ((obs & msk) === (exp & msk)) else begin
      bad++;
      $error("FAIL cycle%0d got=%h want=%h mask=%h", cyc, obs, exp, msk);
    end
    if (mem_req_o) begin
      n_cmd++; glog.push_back(grant_o);
      last_add = mem_add_o; last_blk = mem_req_block_o; last_rw = mem_rw_o;
    end
    if (mem_write_o || mem_read_o) begin n_beat++; last_data = mem_data_o; end
    if (r0_ready_req_o || r1_ready_req_o) n_rr++;
    if (r1_ready_write_o || r1_ready_read_o) n_r1rdy++;
    if (busy_o) n_busy++;
    last_busy = busy_o;
    if (!resetn_i) begin
      phase = 0; pend.delete(); ptr = 1'b0;
    end else begin
      case (phase)
        0: begin
          if (pend.size() != 0) begin
            cur = pend.pop_front(); phase = 1;
          end else if (r0_req_i && r1_req_i) begin
            t0 = mk(1'b0); t1 = mk(1'b1);
            cur = ptr ? t1 : t0;
            pend.push_back(ptr ? t0 : t1);
            phase = 1;
          end else if (r0_req_i) begin
            cur = mk(1'b0); phase = 1;
          end else if (r1_req_i) begin
            cur = mk(1'b1); phase = 1;
          end
        end
        1: if (mem_ready_req_i) begin phase = 2; remaining = cur.blk ? BW : 1; end
        default: if (fired) begin
          remaining--;
          if (remaining == 0) begin phase = 0; ptr = !cur.own; end
        end
      endcase
    end
    cyc++;
    @(negedge clock_i);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((phase != 0 || pend.size() != 0) && n < lim) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(n < lim), 32'd1);
  endtask

  initial begin
    int k;
    int unsigned pick;
    #1 resetn_i = 1'b0;
    @(negedge clock_i);
    step();
    step();
    resetn_i = 1'b1;
    step();

    // Collision right after reset: port 0 first, then port 1 from the pending slot.
    clr();
    r0_read_i = 1'b1; r1_write_i = 1'b1; r1_data_i = 32'h1234_5678;
    r0_req_i = 1'b1; r0_req_block_i = 1'b0; r0_rw_i = 1'b0; r0_add_i = 24'h000010;
    r1_req_i = 1'b1; r1_req_block_i = 1'b0; r1_rw_i = 1'b1; r1_add_i = 24'h000020;
    step();
    r0_req_i = 1'b0; r1_req_i = 1'b0;
    wait_idle(200);
    check("s2_cmds", 32'(n_cmd), 32'd2);
    check("s2_first", glog_at(0), 32'd1);
    check("s2_second", glog_at(1), 32'd2);

`ifdef LEASE_ARB_PERF_COUNTERS_EN
    perf_exp[0] = 32'd1; perf_exp[1] = 32'd1; perf_exp[2] = 32'd1; perf_exp[3] = 32'd0;
`else
    perf_exp[0] = 32'd0; perf_exp[1] = 32'd0; perf_exp[2] = 32'd0; perf_exp[3] = 32'd0;
`endif
    for (int i = 0; i < 4; i++) begin
      perf_sel_i = 2'(i);
      #1;
      check($sformatf("perf%0d", i), perf_data_o, perf_exp[i]);
    end
    @(negedge clock_i);

    // Pointer must be back at port 0: a second collision is won by port 0.
    clr();
    r0_req_i = 1'b1; r1_req_i = 1'b1;
    step();
    r0_req_i = 1'b0; r1_req_i = 1'b0;
    wait_idle(200);
    check("s2_ptr_back", glog_at(0), 32'd1);

    // Port 0 block read at 0x100; port 1 strobes toggle but must be ignored.
    clr();
    r1_read_i = 1'b1; r1_write_i = 1'b1;
    r0_req_i = 1'b1; r0_req_block_i = 1'b1; r0_rw_i = 1'b0; r0_add_i = 24'h000100;
    step();
    r0_req_i = 1'b0;
    wait_idle(200);
    check("s1_cmds", 32'(n_cmd), 32'd1);
    check("s1_add", 32'(last_add), 32'h100);
    check("s1_blk", 32'(last_blk), 32'd1);
    check("s1_rw", 32'(last_rw), 32'd0);
    check("s1_beats", 32'(n_beat), 32'd16);
    check("s1_r1_rdy", 32'(n_r1rdy), 32'd0);
    check("s1_busy_len", 32'(n_busy), 32'd17);

    // Port 1 single write of 0xDEADBEEF held off by mem_ready_write_i for 3 cycles.
    clr();
    mem_ready_write_i = 1'b0;
    r0_write_i = 1'b1; r0_data_i = 32'h0BAD_0BAD;
    r1_write_i = 1'b1; r1_data_i = 32'hDEAD_BEEF;
    r1_req_i = 1'b1; r1_req_block_i = 1'b0; r1_rw_i = 1'b1; r1_add_i = 24'h000055;
    step();
    r1_req_i = 1'b0;
    step();
    step();
    r0_req_i = 1'b1;
    step();
    r0_req_i = 1'b0;
    step();
    check("s3_hold", 32'(n_beat), 32'd0);
    mem_ready_write_i = 1'b1;
    wait_idle(50);
    check("s3_beats", 32'(n_beat), 32'd1);
    check("s3_data", last_data, 32'hDEAD_BEEF);
    check("s3_cmds", 32'(n_cmd), 32'd1);
    step();
    check("s3_idle", 32'(last_busy), 32'd0);

    // ISSUE stalled by mem_ready_req_i for 5 cycles.
    r0_req_i = 1'b1; r0_req_block_i = 1'b0; r0_rw_i = 1'b0; r0_add_i = 24'h0000AA;
    step();
    r0_req_i = 1'b0;
    clr();
    mem_ready_req_i = 1'b0;
    repeat (5) step();
    check("s4_no_cmd", 32'(n_cmd), 32'd0);
    check("s4_no_rr", 32'(n_rr), 32'd0);
    mem_ready_req_i = 1'b1;
    wait_idle(50);
    check("s4_cmd", 32'(n_cmd), 32'd1);
    check("s4_rr", 32'(n_rr), 32'd0);

    // Reset in the middle of a block write, with the collision loser still pending.
    r0_write_i = 1'b1; r1_write_i = 1'b1;
    r0_req_i = 1'b1; r0_req_block_i = 1'b1; r0_rw_i = 1'b1; r0_add_i = 24'h000200;
    r1_req_i = 1'b1; r1_req_block_i = 1'b1; r1_rw_i = 1'b1; r1_add_i = 24'h000300;
    step();
    r0_req_i = 1'b0; r1_req_i = 1'b0;
    clr();
    k = 0;
    while (n_beat < 7 && k < 100) begin step(); k++; end
    check("s5_reach_beat7", 32'(n_beat), 32'd7);
    resetn_i = 1'b0;
    step();
    resetn_i = 1'b1;
    clr();
    repeat (4) step();
    check("s5_pend_dropped", 32'(n_cmd), 32'd0);
    r1_req_i = 1'b1; r1_req_block_i = 1'b0; r1_rw_i = 1'b0; r1_add_i = 24'h000400; r1_read_i = 1'b1;
    step();
    r1_req_i = 1'b0;
    wait_idle(50);
    check("s5_new_cmd", 32'(n_cmd), 32'd1);
    check("s5_new_grant", glog_at(0), 32'd2);

    // Randomized traffic against the transaction-level model.
    for (int c = 0; c < 3000; c++) begin
      mem_ready_req_i   = ($urandom_range(0, 3) != 0);
      mem_ready_write_i = ($urandom_range(0, 3) != 0);
      mem_ready_read_i  = ($urandom_range(0, 3) != 0);
      mem_data_i = $urandom;
      r0_data_i  = $urandom;
      r1_data_i  = $urandom;
      r0_write_i = 1'($urandom_range(0, 1));
      r1_write_i = 1'($urandom_range(0, 1));
      r0_read_i  = 1'($urandom_range(0, 1));
      r1_read_i  = 1'($urandom_range(0, 1));
      r0_req_i = 1'b0;
      r1_req_i = 1'b0;
      if (phase == 0 && pend.size() == 0 && mem_ready_req_i) begin
        pick = $urandom_range(0, 3);
        r0_req_i = pick[0];
        r1_req_i = pick[1];
        r0_req_block_i = ($urandom_range(0, 3) == 0);
        r1_req_block_i = ($urandom_range(0, 3) == 0);
        r0_rw_i  = 1'($urandom_range(0, 1));
        r1_rw_i  = 1'($urandom_range(0, 1));
        r0_add_i = AW'($urandom);
        r1_add_i = AW'($urandom);
      end
      step();
    end
    r0_req_i = 1'b0; r1_req_i = 1'b0;
    mem_ready_req_i = 1'b1; mem_ready_write_i = 1'b1; mem_ready_read_i = 1'b1;
    r0_write_i = 1'b1; r1_write_i = 1'b1; r0_read_i = 1'b1; r1_read_i = 1'b1;
    wait_idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lease_cache_mem_arbiter.md
Name: lease_cache_mem_arbiter

Overview:
- Shares the single internal memory controller request/buffer port between two lease-cache requesters: port 0 is the instruction cache, port 1 is the data cache.
- Sits between the caches' req/rw/add/write/read/data memory-side ports and the memory controller.
- Each granted request is serialised into one exclusive transaction: one command, then 1 or BLOCK_WORDS data beats.
- Uses round-robin priority and a one-deep pending slot for the request that loses a same-cycle collision.

Parameters:
- BW_ADDR, 24, width of word address on add buses.
- BLOCK_WORDS, 16, beats per block transfer (power of two, >=2).

Ports:
- clock_i  in  1  controller clock; all state on rising edge.
- resetn_i  in  1  asynchronous active-low reset.
- r0_req_i, r1_req_i  in  1  one-cycle request pulse from requester.
- r0_req_block_i, r1_req_block_i  in  1  1: block transfer, 0: single word.
- r0_rw_i, r1_rw_i  in  1  1: write to memory, 0: read.
- r0_add_i, r1_add_i  in  BW_ADDR  request word address.
- r0_write_i, r1_write_i  in  1  write-beat strobe.
- r0_read_i, r1_read_i  in  1  read-beat strobe.
- r0_data_i, r1_data_i  in  32  write-beat data.
- r0_ready_req_o, r1_ready_req_o  out  1  gated request-ready.
- r0_ready_write_o, r1_ready_write_o  out  1  gated write-ready.
- r0_ready_read_o, r1_ready_read_o  out  1  gated read-ready.
- rd_data_o  out  32  read data, broadcast to both requesters (equals mem_data_i).
- mem_ready_req_i, mem_ready_write_i, mem_ready_read_i  in  1  controller buffer readies.
- mem_data_i  in  32  read data from the buffer.
- mem_req_o, mem_req_block_o, mem_rw_o  out  1  issued command.
- mem_add_o  out  BW_ADDR  issued address.
- mem_write_o, mem_read_o  out  1  forwarded beat strobes.
- mem_data_o  out  32  forwarded write data.
- grant_o  out  2  one-hot owner of the current transaction; 00 when idle.
- busy_o  out  1  high when state is not IDLE.

Behaviour:
- Reset (async, resetn_i=0):
  - state=IDLE; priority pointer=0 (port 0 wins next collision).
  - Pending slot invalid; beat counter=0.
  - All outputs 0, except rd_data_o, which is combinational.
  - Reset mid-transaction aborts it and drops any pending request; no further beats are forwarded.
- States: IDLE -> ISSUE -> XFER -> IDLE.
- IDLE:
  - rX_ready_req_o = mem_ready_req_i for both ports, unless the pending slot is valid; then both are 0.
  - Pending slot valid: load it as the active request and go to ISSUE.
  - Else one req pulse: latch {block, rw, add} and owner into the active register, go to ISSUE.
  - Else both pulse in the same cycle: the pointer's port wins and becomes active; the loser is latched into the pending slot. Go to ISSUE.
- ISSUE:
  - rX_ready_req_o=0 for both ports.
  - When mem_ready_req_i=1: drive mem_req_o=1 for exactly one cycle with the latched block/rw/add.
  - Beat target = BLOCK_WORDS if block=1, else 1. Counter cleared. Go to XFER.
- XFER:
  - Only the owner sees readies: owner's ready_write_o = mem_ready_write_i when rw=1; owner's ready_read_o = mem_ready_read_i when rw=0. All others are 0.
  - mem_write_o = owner write_i & mem_ready_write_i & rw.
  - mem_read_o = owner read_i & mem_ready_read_i & !rw.
  - mem_data_o = owner data_i.
  - Non-owner strobes are ignored.
  - Each forwarded beat increments the counter.
  - On the beat where counter == target-1: go to IDLE, pointer = !owner, grant_o cleared the next cycle.
- A request pulse from a non-owner while busy is ignored, except the collision loser captured above. Requesters must honour their ready_req_o.
- Counter width is clog2(BLOCK_WORDS)+1; it never wraps.
- Zero bubble cycles are added beyond the IDLE->ISSUE transition.

Optional Feature:
- Macro: LEASE_ARB_PERF_COUNTERS_EN.
- When defined, adds 32-bit saturating counters:
  - grants per port;
  - collision cycles (both ports pulsed req the same cycle);
  - stall cycles (ISSUE with mem_ready_req_i=0).
- Counters are exposed on perf_sel_i (2 bits) / perf_data_o (32 bits) ports.
- Counters clear on reset and saturate at 0xFFFFFFFF.
- When undefined, the ports still exist, perf_data_o ties to 0, and no counter flops are synthesised.

Test Plan:
- Port0 block read at add 0x000100, mem readies held high:
  - mem_req_o pulses once with add 0x000100, block=1, rw=0;
  - 16 mem_read_o beats are forwarded;
  - r1 readies stay 0 throughout;
  - busy_o falls after beat 16.
- Simultaneous r0/r1 req pulses after reset:
  - port0 is served first (grant_o=01), then port1 immediately (grant_o=10) without r1 re-requesting;
  - pointer ends at 0.
- Port1 single-word write, data 0xDEADBEEF, mem_ready_write_i low for 3 cycles:
  - no mem_write_o until ready rises;
  - exactly one beat with mem_data_o=0xDEADBEEF;
  - return to IDLE.
- ISSUE with mem_ready_req_i low for 5 cycles: mem_req_o stays 0, then one pulse; both rX_ready_req_o stay 0 throughout.
- resetn_i asserted at beat 7 of a 16-beat block write:
  - all outputs 0 immediately;
  - pending dropped;
  - after release, a new port1 request is granted normally.
- With LEASE_ARB_PERF_COUNTERS_EN: after scenario 2, grant counters read 1/1 and the collision counter reads 1. Without the macro, perf_data_o reads 0.
